multiword_adder_seq: RTL and testbench

//   Sequencer that performs a BIT*WORDS-bit addition by issuing BIT-bit chunks,
//   LSW first, to an external combinational BIT-bit adder core (e.g. the CLA).
//   - Drives the core's operand and carry-in pins; captures its sum and carry-out.
//   - Chains carry through a register: one chunk per clock.
//   - Wide adds reuse one narrow core instead of a wide combinational carry path.

---
 rtl/multiword_adder_seq.sv | 124 ++++++++++++
 tb/tb_multiword_adder_seq.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/multiword_adder_seq.sv
// Chains a narrow external adder core over WORDS chunks, LSW first.
// Optional MULTIWORD_OVERFLOW_EN adds o_overflow (signed W-bit overflow).
module multiword_adder_seq #(
  parameter int BIT   = 32,
  parameter int WORDS = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  input  logic                 i_start,
  input  logic [BIT*WORDS-1:0] i_data_a,
  input  logic [BIT*WORDS-1:0] i_data_b,
  input  logic                 i_carry,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [BIT*WORDS-1:0] o_data_s,
  output logic                 o_carry,
`ifdef MULTIWORD_OVERFLOW_EN
  output logic                 o_overflow,
`endif
  output logic [BIT-1:0]       o_add_a,
  output logic [BIT-1:0]       o_add_b,
  output logic                 o_add_cin,
  input  logic [BIT-1:0]       i_add_s,
  input  logic                 i_add_cout
);

  localparam int W  = BIT * WORDS;
  localparam int CW = $clog2(WORDS);
  localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [W-1:0]  s_q;
  logic          c_q;
  logic          co_q;
  logic          done_q;
  logic [31:0]   base_d;
`ifdef MULTIWORD_OVERFLOW_EN
  logic          ovf_q;
`endif

  assign base_d = 32'(cnt_q) * 32'(BIT);

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      c_q     <= 1'b0;
      co_q    <= 1'b0;
      done_q  <= 1'b0;
`ifdef MULTIWORD_OVERFLOW_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (i_start) begin
            a_q     <= i_data_a;
            b_q     <= i_data_b;
            c_q     <= i_carry;
            cnt_q   <= '0;
            s_q     <= '0;
            co_q    <= 1'b0;
`ifdef MULTIWORD_OVERFLOW_EN
            ovf_q   <= 1'b0;
`endif
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          s_q[base_d +: BIT] <= i_add_s;
          c_q                <= i_add_cout;
          if (cnt_q == LAST) begin
            cnt_q   <= '0;
            co_q    <= i_add_cout;
            done_q  <= 1'b1;
            state_q <= S_DONE;
`ifdef MULTIWORD_OVERFLOW_EN
            // top chunk sum bit is the result sign
            ovf_q   <= (a_q[W-1] == b_q[W-1]) &&
                       (i_add_s[BIT-1] != a_q[W-1]);
`endif
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    o_add_a   = '0;
    o_add_b   = '0;
    o_add_cin = 1'b0;
    if (state_q == S_RUN) begin
      o_add_a   = a_q[base_d +: BIT];
      o_add_b   = b_q[base_d +: BIT];
      o_add_cin = c_q;
    end
  end

  assign o_busy   = (state_q != S_IDLE);
  assign o_done   = done_q;
  assign o_data_s = s_q;
  assign o_carry  = co_q;
`ifdef MULTIWORD_OVERFLOW_EN
  assign o_overflow = ovf_q;
`endif

endmodule

// File: tb/tb_multiword_adder_seq.sv
// Bench for multiword_adder_seq: reference model plus directed vectors.
// Honours MULTIWORD_OVERFLOW_EN for the o_overflow checks.
module tb_multiword_adder_seq;

  localparam int BIT   = 32;
  localparam int WORDS = 4;
  localparam int W     = BIT * WORDS;

  logic           clk = 1'b0;
  logic           rstn;
  logic           start;
  logic [W-1:0]   da;
  logic [W-1:0]   db;
  logic           cin;
  logic           busy;
  logic           done;
  logic [W-1:0]   sum;
  logic           cout;
  logic           ovf;
  logic [BIT-1:0] add_a;
  logic [BIT-1:0] add_b;
  logic           add_cin;
  logic [BIT-1:0] add_s;
  logic           add_cout;

  int errors = 0;
  int checks = 0;
  int ndone  = 0;

  always #5 clk = ~clk;

  // stand-in for the external combinational core
  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + 33'(add_cin);

  multiword_adder_seq #(.BIT(BIT), .WORDS(WORDS)) dut (
    .i_clk      (clk),
    .i_rstn     (rstn),
    .i_start    (start),
    .i_data_a   (da),
    .i_data_b   (db),
    .i_carry    (cin),
    .o_busy     (busy),
    .o_done     (done),
    .o_data_s   (sum),
    .o_carry    (cout),
`ifdef MULTIWORD_OVERFLOW_EN
    .o_overflow (ovf),
`endif
    .o_add_a    (add_a),
    .o_add_b    (add_b),
    .o_add_cin  (add_cin),
    .i_add_s    (add_s),
    .i_add_cout (add_cout)
  );

`ifndef MULTIWORD_OVERFLOW_EN
  assign ovf = 1'b0;
`endif

  task automatic chk(input string name, input logic [W:0] got,
                     input logic [W:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic logic [W:0] wide_sum(input logic [W-1:0] a,
                                          input logic [W-1:0] b,
                                          input logic c);
    return {1'b0, a} + {1'b0, b} + (W+1)'(c);
  endfunction

  function automatic logic carry_into(input logic [W-1:0] a,
                                      input logic [W-1:0] b,
                                      input logic c, input int k);
    logic [W:0] mask;
    logic [W:0] t;
    mask = ((W+1)'(1) << (k * BIT)) - 1;
    t = ({1'b0, a} & mask) + ({1'b0, b} & mask) + (W+1)'(c);
    return t[k * BIT];
  endfunction

  // model: phase 0 idle, 1..WORDS running, WORDS+1 result cycle
  int         ph = 0;
  bit         mv = 0;
  logic [W-1:0] pa, pb, exp_s;
  logic       pc, exp_c, exp_v;

  always @(posedge clk) begin
    logic [W:0] f;
    mv <= 1'b1;
    if (!rstn) begin
      ph <= 0; exp_s <= '0; exp_c <= 1'b0; exp_v <= 1'b0;
    end else if (ph == 0) begin
      if (start) begin
        ph <= 1; pa <= da; pb <= db; pc <= cin;
        exp_s <= '0; exp_c <= 1'b0; exp_v <= 1'b0;
      end
    end else if (ph == WORDS) begin
      f = wide_sum(pa, pb, pc);
      ph    <= WORDS + 1;
      exp_s <= f[W-1:0];
      exp_c <= f[W];
`ifdef MULTIWORD_OVERFLOW_EN
      exp_v <= (pa[W-1] == pb[W-1]) && (f[W-1] != pa[W-1]);
`endif
    end else if (ph == WORDS + 1) begin
      ph <= 0;
    end else begin
      ph <= ph + 1;
    end
  end

  always @(negedge clk) begin
    if (mv) begin
      if (done === 1'b1) ndone++;
      chk("busy", (W+1)'(busy), (W+1)'(ph != 0));
      chk("done", (W+1)'(done), (W+1)'(ph == WORDS + 1));
      if (ph == 0 || ph == WORDS + 1) begin
        chk("sum", {1'b0, sum}, {1'b0, exp_s});
        chk("carry", (W+1)'(cout), (W+1)'(exp_c));
        chk("ovf", (W+1)'(ovf), (W+1)'(exp_v));
        chk("core_idle", (W+1)'({add_a, add_b, add_cin}), '0);
      end else begin
        chk("core_a", (W+1)'(add_a), (W+1)'(pa[(ph-1)*BIT +: BIT]));
        chk("core_b", (W+1)'(add_b), (W+1)'(pb[(ph-1)*BIT +: BIT]));
        chk("core_cin", (W+1)'(add_cin),
            (W+1)'(carry_into(pa, pb, pc, ph - 1)));
      end
    end
  end

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, output logic [W-1:0] s,
                        output logic co, output logic ov, output int lat);
    bit got;
    start = 1'b1; da = a; db = b; cin = c;
    @(posedge clk); #1;
    start = 1'b0; da = ~a; db = ~b; cin = ~c;
    got = 0; lat = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin got = 1; lat = i; break; end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL done_timeout got=none exp=pulse");
    end
    s = sum; co = cout; ov = ovf;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [W-1:0] s, ra, rb;
    logic co, ov, rc;
    int lat, n0;
    bit got;

    rstn = 1'b0; start = 1'b1; da = '1; db = '1; cin = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("t1_busy", (W+1)'(busy), '0);
    chk("t1_outs", {cout, sum}, '0);
    rstn = 1'b1; start = 1'b0;
    @(posedge clk); #1;

    run_op(128'd1, 128'd2, 1'b0, s, co, ov, lat);
    chk("t2_sum", {co, s}, 129'd3);
    chk("t2_latency", (W+1)'(lat), (W+1)'(WORDS));

    run_op(128'h0000_0000_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'd1, 1'b0,
           s, co, ov, lat);
    chk("t3a_sum", {co, s}, {1'b0, 128'h0000_0001_0000_0000_0000_0000_0000_0000});
    run_op('1, '0, 1'b1, s, co, ov, lat);
    chk("t3b_sum", {co, s}, {1'b1, 128'd0});

    n0 = ndone;
    start = 1'b1; da = 128'd1; db = 128'd2; cin = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; da = 128'd5; db = 128'd5;
    @(posedge clk); #1;
    start = 1'b0;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin got = 1; break; end
    end
    chk("t4_done_seen", (W+1)'(got), (W+1)'(1));
    chk("t4_sum", {cout, sum}, 129'd3);
    repeat (8) @(posedge clk);
    #1;
    chk("t4_one_done", (W+1)'(ndone - n0), (W+1)'(1));

    n0 = ndone;
    start = 1'b1; da = 128'd7; db = 128'd8; cin = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    chk("t5_busy", (W+1)'(busy), '0);
    chk("t5_outs", {cout, sum}, '0);
    repeat (8) @(posedge clk);
    #1;
    chk("t5_no_done", (W+1)'(ndone - n0), '0);
    run_op(128'd10, 128'd20, 1'b1, s, co, ov, lat);
    chk("t5_fresh", {co, s}, 129'd31);

    run_op({1'b0, {(W-1){1'b1}}}, 128'd1, 1'b0, s, co, ov, lat);
    chk("t6_sum", {co, s}, {1'b0, 1'b1, {(W-1){1'b0}}});
`ifdef MULTIWORD_OVERFLOW_EN
    chk("t6_ovf", (W+1)'(ov), (W+1)'(1));
`endif

    for (int n = 0; n < 200; n++) begin
      ra = {$urandom, $urandom, $urandom, $urandom};
      rb = {$urandom, $urandom, $urandom, $urandom};
      rc = 1'($urandom_range(0, 1));
      if (n == 0) rb = ~ra;
      run_op(ra, rb, rc, s, co, ov, lat);
      chk("rand_sum", {co, s}, wide_sum(ra, rb, rc));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
